alfa_sequenciador: RTL and testbench

Programmable melody sequencer that drives the xylophone keying interface (`Tom`, `Notas`) on its own, replacing hand-written key stimulus. Software or a test bench loads up to 16 note entries (tone, note, duration) into an internal memory, then pulses `inicia`. The block plays the entries in order, holding each key for a programmed time followed by a one-cycle release gap, and can loop. Its outputs connect directly to the `Tom`/`Notas` inputs of the xylophone decoder.

---
 rtl/alfa_sequenciador_if.sv | 35 +++
 rtl/alfa_sequenciador.sv | 149 ++++++++++++++
 tb/tb_alfa_sequenciador.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alfa_sequenciador_if.sv
// alfa_sequenciador bus: memory write port, play control, xylophone keys.
// master = host/bench side, slave = sequencer side.
interface alfa_sequenciador_if;
  logic       escreve;
  logic [3:0] endereco;
  logic       dado_tom;
  logic [2:0] dado_notas;
  logic [3:0] dado_dur;
  logic [4:0] tamanho;
  logic       repete;
  logic       inicia;
  logic       para;
  logic       Tom;
  logic [2:0] Notas;
  logic       valida;
  logic       tocando;
  logic [3:0] indice;
  logic       fim;

  modport master (
    output escreve, endereco, dado_tom,
    output dado_notas, dado_dur,
    output tamanho, repete, inicia, para,
    input  Tom, Notas, valida,
    input  tocando, indice, fim
  );

  modport slave (
    input  escreve, endereco, dado_tom,
    input  dado_notas, dado_dur,
    input  tamanho, repete, inicia, para,
    output Tom, Notas, valida,
    output tocando, indice, fim
  );
endinterface

// File: rtl/alfa_sequenciador.sv
// Melody sequencer: plays up to 16 {tom,notas,dur} entries on Tom/Notas.
// Ports: clock, reset_n (async low), bus (write port, control, key outputs).
module alfa_sequenciador #(
  parameter int PRESCALE = 4
) (
  input  logic clock,
  input  logic reset_n,
  alfa_sequenciador_if.slave bus
);
  localparam int CW = 4 + $clog2(PRESCALE);

  typedef enum logic [1:0] {
    OCIOSO,
    TOCA,
    INTERVALO
  } estado_t;

  estado_t est, est_n;

  logic [7:0]    mem [16];
  logic          tom_q, tom_n;
  logic [2:0]    notas_q, notas_n;
  logic          valida_q, valida_n;
  logic [3:0]    idx_q, idx_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          fim_q, fim_n;
  logic [4:0]    len_q, len_n;
  logic          rep_q, rep_n;
  logic [3:0]    rd_idx;
  logic          carrega;
  logic [7:0]    ent;
  logic [CW-1:0] carga;
  logic          ultimo;

  always_ff @(posedge clock) begin
    if (bus.escreve)
      mem[bus.endereco] <= {bus.dado_tom,
                            bus.dado_notas,
                            bus.dado_dur};
  end

  // Entry fetched the cycle its playback starts,
  // so earlier writes to it are honoured.
  assign ent   = mem[rd_idx];
  assign carga = CW'((32'(ent[3:0]) + 32'd1)
                 * 32'(PRESCALE) - 32'd1);
  assign ultimo = ({1'b0, idx_q} == len_q - 5'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      est      <= OCIOSO;
      tom_q    <= 1'b0;
      notas_q  <= 3'd0;
      valida_q <= 1'b0;
      idx_q    <= 4'd0;
      cnt_q    <= '0;
      fim_q    <= 1'b0;
      len_q    <= 5'd0;
      rep_q    <= 1'b0;
    end else begin
      est      <= est_n;
      tom_q    <= tom_n;
      notas_q  <= notas_n;
      valida_q <= valida_n;
      idx_q    <= idx_n;
      cnt_q    <= cnt_n;
      fim_q    <= fim_n;
      len_q    <= len_n;
      rep_q    <= rep_n;
    end
  end

  always_comb begin
    est_n    = est;
    tom_n    = tom_q;
    notas_n  = notas_q;
    valida_n = valida_q;
    idx_n    = idx_q;
    cnt_n    = cnt_q;
    fim_n    = 1'b0;
    len_n    = len_q;
    rep_n    = rep_q;
    rd_idx   = 4'd0;
    carrega  = 1'b0;

    if (bus.para) begin
      est_n    = OCIOSO;
      tom_n    = 1'b0;
      notas_n  = 3'd0;
      valida_n = 1'b0;
      idx_n    = 4'd0;
      cnt_n    = '0;
    end else begin
      unique case (est)
        OCIOSO: begin
          if (bus.inicia && bus.tamanho != 5'd0) begin
            est_n   = TOCA;
            idx_n   = 4'd0;
            carrega = 1'b1;
            len_n   = (bus.tamanho > 5'd16) ? 5'd16
                                            : bus.tamanho;
            rep_n   = bus.repete;
          end
        end
        TOCA: begin
          if (cnt_q == '0) begin
            est_n    = INTERVALO;
            tom_n    = 1'b0;
            notas_n  = 3'd0;
            valida_n = 1'b0;
          end else begin
            cnt_n = cnt_q - 1'b1;
          end
        end
        INTERVALO: begin
          if (!ultimo) begin
            est_n   = TOCA;
            rd_idx  = idx_q + 4'd1;
            idx_n   = rd_idx;
            carrega = 1'b1;
          end else if (rep_q) begin
            est_n   = TOCA;
            idx_n   = 4'd0;
            carrega = 1'b1;
          end else begin
            est_n = OCIOSO;
            idx_n = 4'd0;
            fim_n = 1'b1;
          end
        end
        default: est_n = OCIOSO;
      endcase
    end

    if (carrega) begin
      tom_n    = ent[7];
      notas_n  = ent[6:4];
      valida_n = 1'b1;
      cnt_n    = carga;
    end
  end

  assign bus.Tom     = tom_q;
  assign bus.Notas   = notas_q;
  assign bus.valida  = valida_q;
  assign bus.tocando = (est != OCIOSO);
  assign bus.indice  = idx_q;
  assign bus.fim     = fim_q;
endmodule

// File: tb/tb_alfa_sequenciador.sv
// Bench for alfa_sequenciador: trace scoreboard plus scenario table.
// Expected per-cycle key outputs are derived from a memory image.
module tb_alfa_sequenciador;
  localparam int P = 2;

  typedef struct packed {
    logic       valida;
    logic       tom;
    logic [2:0] notas;
    logic       tocando;
    logic [3:0] indice;
    logic       fim;
  } obs_t;

  typedef struct {
    logic [4:0] tam;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    int         poke;
    int         exp_fim;
  } vec_t;

  logic clock = 1'b0;
  logic clk_en = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] img [16];
  obs_t exp_q [$];

  alfa_sequenciador_if bus ();

  alfa_sequenciador #(.PRESCALE(P)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial forever #5 clock = clk_en ? ~clock : clock;

  function automatic obs_t amostra();
    obs_t o;
    o.valida  = bus.valida;
    o.tom     = bus.Tom;
    o.notas   = bus.Notas;
    o.tocando = bus.tocando;
    o.indice  = bus.indice;
    o.fim     = bus.fim;
    return o;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic t,
                    input logic [2:0] n,
                    input logic [3:0] d);
    @(negedge clock);
    bus.escreve    = 1'b1;
    bus.endereco   = a;
    bus.dado_tom   = t;
    bus.dado_notas = n;
    bus.dado_dur   = d;
    img[a]         = {t, n, d};
    @(negedge clock);
    bus.escreve = 1'b0;
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('0);
  endtask

  task automatic push_trace(input logic [4:0] tam,
                            input logic rep);
    int   len;
    obs_t o;
    len = (tam > 5'd16) ? 16 : int'(tam);
    for (int i = 0; i < len; i++) begin
      o         = '0;
      o.valida  = 1'b1;
      o.tom     = img[i][7];
      o.notas   = img[i][6:4];
      o.tocando = 1'b1;
      o.indice  = 4'(i);
      for (int c = 0; c < (int'(img[i][3:0]) + 1) * P; c++)
        exp_q.push_back(o);
      o.valida = 1'b0;
      o.tom    = 1'b0;
      o.notas  = 3'd0;
      exp_q.push_back(o);
    end
    if (!rep) begin
      o     = '0;
      o.fim = 1'b1;
      exp_q.push_back(o);
      push_idle(1);
    end
  endtask

  task automatic go(input logic [4:0] tam,
                    input logic rep);
    bus.tamanho = tam;
    bus.repete  = rep;
    bus.inicia  = 1'b1;
  endtask

  // kind 1: extra inicia; kind 2: live rewrite of entry 2
  task automatic drain(input int kind,
                       input int at,
                       output int fim_at);
    int   i;
    obs_t e;
    obs_t a;
    fim_at = -1;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      bus.inicia  = 1'b0;
      bus.para    = 1'b0;
      bus.escreve = 1'b0;
      e = exp_q.pop_front();
      a = amostra();
      chk($sformatf("trace[%0d]", i), 32'(a), 32'(e));
      if (a.fim && fim_at < 0) fim_at = i;
      if (i == at) begin
        if (kind == 1) bus.inicia = 1'b1;
        if (kind == 2) begin
          bus.escreve    = 1'b1;
          bus.endereco   = 4'd2;
          bus.dado_tom   = 1'b1;
          bus.dado_notas = 3'b011;
          bus.dado_dur   = 4'd0;
        end
      end
      i++;
    end
  endtask

  vec_t vt [4];
  int   fa;
  obs_t o;

  initial begin
    vt[0] = '{5'd3, 4'd0,  4'd1, 4'd2, 1,  15};
    vt[1] = '{5'd1, 4'd3,  4'd0, 4'd0, -1, 9};
    vt[2] = '{5'd2, 4'd0,  4'd0, 4'd0, -1, 6};
    vt[3] = '{5'd3, 4'd15, 4'd0, 4'd1, -1, 41};

    bus.escreve    = 1'b0;
    bus.endereco   = 4'd0;
    bus.dado_tom   = 1'b0;
    bus.dado_notas = 3'd0;
    bus.dado_dur   = 4'd0;
    bus.tamanho    = 5'd0;
    bus.repete     = 1'b0;
    bus.inicia     = 1'b0;
    bus.para       = 1'b0;

    // reset with the clock stopped
    #20;
    chk("rst_outputs", 32'(amostra()), 32'd0);
    reset_n = 1'b1;
    #3 clk_en = 1'b1;
    push_idle(4);
    drain(0, -1, fa);

    // scenario table
    for (int v = 0; v < 4; v++) begin
      wr(4'd0, 1'b0, 3'b001, vt[v].d0);
      wr(4'd1, 1'b1, 3'b101, vt[v].d1);
      wr(4'd2, 1'b0, 3'b111, vt[v].d2);
      go(vt[v].tam, 1'b0);
      push_trace(vt[v].tam, 1'b0);
      drain(vt[v].poke < 0 ? 0 : 1, vt[v].poke, fa);
      chk($sformatf("fim_at[%0d]", v), 32'(fa),
          32'(vt[v].exp_fim));
    end

    // loop, wrap, then stop mid-note
    wr(4'd0, 1'b0, 3'b001, 4'd0);
    wr(4'd1, 1'b1, 3'b101, 4'd1);
    wr(4'd2, 1'b0, 3'b111, 4'd2);
    go(5'd3, 1'b1);
    push_trace(5'd3, 1'b1);
    o = '0;
    o.valida  = 1'b1;
    o.notas   = 3'b001;
    o.tocando = 1'b1;
    exp_q.push_back(o);
    drain(0, -1, fa);
    chk("loop_no_fim", 32'(fa), 32'hFFFF_FFFF);
    bus.para = 1'b1;
    @(negedge clock);
    bus.para = 1'b0;
    chk("para_stop", 32'(amostra()), 32'd0);
    push_idle(2);
    drain(0, -1, fa);

    // ignored starts
    go(5'd0, 1'b0);
    push_idle(3);
    drain(0, -1, fa);
    go(5'd3, 1'b0);
    bus.para = 1'b1;
    push_idle(3);
    drain(0, -1, fa);

    // length above 16 clamps to 16
    for (int i = 0; i < 16; i++)
      wr(4'(i), i[3], 3'(i), 4'd0);
    go(5'd20, 1'b0);
    push_trace(5'd20, 1'b0);
    drain(0, -1, fa);
    chk("fim_at_len20", 32'(fa), 32'd48);

    // live write of entry 2 while entry 0 plays
    wr(4'd0, 1'b0, 3'b001, 4'd0);
    wr(4'd1, 1'b1, 3'b101, 4'd0);
    wr(4'd2, 1'b0, 3'b000, 4'd5);
    img[2] = {1'b1, 3'b011, 4'd0};
    go(5'd3, 1'b0);
    push_trace(5'd3, 1'b0);
    drain(2, 0, fa);
    chk("fim_at_live", 32'(fa), 32'd9);

    // async reset between edges, mid-note
    go(5'd3, 1'b0);
    @(negedge clock);
    bus.inicia = 1'b0;
    @(negedge clock);
    chk("pre_rst_valida", 32'(bus.valida), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("async_rst", 32'(amostra()), 32'd0);
    #1 reset_n = 1'b1;
    push_idle(4);
    drain(0, -1, fa);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
